// File: rtl/multi_pattern_scanner_if.sv
// multi_pattern_scanner_if: start/done handshake, pattern set, ROM port and results of the scanner.
// The slave modport is the scanner side; the master modport is the controller/ROM side.
interface multi_pattern_scanner_if #(
  parameter int SYM_W   = 4,
  parameter int PAT_LEN = 3,
  parameter int NUM_PAT = 6,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8
);
  logic                                       start;
  logic [NUM_PAT-1:0][PAT_LEN-1:0][SYM_W-1:0] pat;
  logic [ADDR_W-1:0]                          rom_addr;
  logic [SYM_W-1:0]                           rom_data;
  logic                                       busy;
  logic                                       done;
  logic [NUM_PAT-1:0][CNT_W-1:0]              cnt;
  logic [NUM_PAT-1:0]                         sat;
  modport master(output start, pat, rom_data, input rom_addr, busy, done, cnt, sat);
  modport slave(input start, pat, rom_data, output rom_addr, busy, done, cnt, sat);
endinterface

// File: rtl/multi_pattern_scanner.sv
// multi_pattern_scanner: counts NUM_PAT patterns of PAT_LEN symbols in parallel over a sync ROM stream.
// Define OVERLAP_EN to count every window match; by default matches of one pattern never overlap.
module multi_pattern_scanner #(
  parameter int SYM_W   = 4,
  parameter int PAT_LEN = 3,
  parameter int NUM_PAT = 6,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  multi_pattern_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRIME, SCAN, FIN} state_t;
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [SYM_W-1:0] END_SYM = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic last_q, last_d;
  logic [NUM_PAT-1:0][PAT_LEN-1:0][SYM_W-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0][SYM_W-1:0] win_q, win_d;
  logic [PAT_LEN:0][SYM_W-1:0] win_ext;
  logic [FW-1:0] fill_q, fill_d;
  logic end_q, end_d;
  logic [NUM_PAT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_PAT-1:0] sat_q, sat_d, hit;
  logic is_end;
`ifndef OVERLAP_EN
  localparam logic [FW-1:0] BLK_INIT = FW'(PAT_LEN - 1);
  logic [NUM_PAT-1:0][FW-1:0] blk_q, blk_d;
`endif
  assign win_ext = {bus.rom_data, win_q};
  assign is_end = bus.rom_data == END_SYM;
  assign bus.rom_addr = addr_q;
  assign bus.busy = state_q == PRIME || state_q == SCAN;
  assign bus.done = state_q == FIN;
  assign bus.cnt = cnt_q;
  assign bus.sat = sat_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    last_d = last_q;
    pat_d = pat_q;
    win_d = win_q;
    fill_d = fill_q;
    end_d = end_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    hit = '0;
`ifndef OVERLAP_EN
    blk_d = blk_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = PRIME;
        pat_d = bus.pat;
        addr_d = '0;
        last_d = 1'b0;
        win_d = '0;
        fill_d = '0;
        end_d = 1'b0;
        cnt_d = '0;
        sat_d = '0;
`ifndef OVERLAP_EN
        blk_d = '0;
`endif
      end
      PRIME: begin
        addr_d = ADDR_W'(1);
        state_d = SCAN;
      end
      SCAN: begin
        addr_d = addr_q == ADDR_MAX ? addr_q : addr_q + 1'b1;
        last_d = addr_q == ADDR_MAX;
        if (!is_end) begin
          win_d = win_ext[PAT_LEN:1];
          fill_d = fill_q == FULL ? fill_q : fill_q + 1'b1;
          end_d = 1'b0;
          for (int p = 0; p < NUM_PAT; p++) begin
`ifdef OVERLAP_EN
            hit[p] = fill_d == FULL && win_d == pat_q[p];
`else
            hit[p] = fill_d == FULL && win_d == pat_q[p] && blk_q[p] == '0;
            blk_d[p] = hit[p] ? BLK_INIT : blk_q[p] != '0 ? blk_q[p] - 1'b1 : '0;
`endif
            cnt_d[p] = hit[p] && cnt_q[p] != CNT_MAX ? cnt_q[p] + 1'b1 : cnt_q[p];
            sat_d[p] = sat_q[p] | (hit[p] && cnt_q[p] == CNT_MAX);
          end
        end else begin
          // a separator: nothing before it may combine with anything after it
          win_d = '0;
          fill_d = '0;
          end_d = 1'b1;
`ifndef OVERLAP_EN
          blk_d = '0;
`endif
        end
        state_d = (is_end && end_q) || last_q ? FIN : SCAN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      last_q <= 1'b0;
      pat_q <= '0;
      win_q <= '0;
      fill_q <= '0;
      end_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= '0;
`ifndef OVERLAP_EN
      blk_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      last_q <= last_d;
      pat_q <= pat_d;
      win_q <= win_d;
      fill_q <= fill_d;
      end_q <= end_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
`ifndef OVERLAP_EN
      blk_q <= blk_d;
`endif
    end
  end
endmodule

// File: tb/tb_multi_pattern_scanner.sv
// tb_multi_pattern_scanner: scoreboard bench for multi_pattern_scanner, built with CNT_W=4 so saturation is reachable.
`timescale 1ns/1ps
module tb_multi_pattern_scanner;
  localparam int SYM_W = 4, PAT_LEN = 3, NUM_PAT = 6, ADDR_W = 8, CNT_W = 4;
  typedef logic [NUM_PAT-1:0][CNT_W-1:0] cnt_t;
  typedef logic [PAT_LEN-1:0][SYM_W-1:0] one_t;
  typedef logic [NUM_PAT-1:0][PAT_LEN-1:0][SYM_W-1:0] pat_t;
  typedef struct {cnt_t cnt; logic [NUM_PAT-1:0] sat; int lat;} exp_t;
  logic clk = 0, rst = 1;
  logic [SYM_W-1:0] mem [2**ADDR_W];
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  multi_pattern_scanner_if #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN), .NUM_PAT(NUM_PAT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bif();
  multi_pattern_scanner #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN), .NUM_PAT(NUM_PAT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bif.rom_data <= mem[bif.rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  function automatic one_t mk(input int a, input int b, input int c);
    one_t r;
    r[0] = SYM_W'(a);
    r[1] = SYM_W'(b);
    r[2] = SYM_W'(c);
    return r;
  endfunction
  function automatic void load(input int s[$]);
    foreach (mem[a]) mem[a] = '0;
    foreach (s[i]) mem[i] = SYM_W'(s[i]);
  endfunction
  // Reference: walk the ROM segment by segment, comparing each full window against the patterns.
  function automatic exp_t model(input pat_t pt);
    exp_t e;
    int seg = 0;
    bit prev_end = 0;
    bit eq;
`ifndef OVERLAP_EN
    int last[NUM_PAT];
    foreach (last[p]) last[p] = -1;
`endif
    e.cnt = '0;
    e.sat = '0;
    e.lat = 2;
    for (int a = 0; a < 2**ADDR_W; a++) begin
      e.lat++;
      if (mem[a] == '1) begin
        if (prev_end) break;
        prev_end = 1;
        seg = a + 1;
        continue;
      end
      prev_end = 0;
      if (a - seg + 1 < PAT_LEN) continue;
      for (int p = 0; p < NUM_PAT; p++) begin
        eq = 1;
        for (int i = 0; i < PAT_LEN; i++) if (mem[a - PAT_LEN + 1 + i] != pt[p][i]) eq = 0;
`ifndef OVERLAP_EN
        if (a - PAT_LEN + 1 <= last[p]) eq = 0;
        if (eq) last[p] = a;
`endif
        if (eq) begin
          if (e.cnt[p] == '1) e.sat[p] = 1;
          else e.cnt[p] = e.cnt[p] + 1'b1;
        end
      end
    end
    return e;
  endfunction
  task automatic run(input pat_t pt, input bit poke);
    exp_t e;
    int lat;
    bif.pat = pt;
    sb.push_back(model(pt));
    @(posedge clk); #1 bif.start = 1;
    @(posedge clk); #1 bif.start = 0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (lat == 1) chk("busy_after_start", bif.busy, 1);
      if (bif.done || lat > 400) break;
      if (poke && lat == 4) begin
        bif.start = 1;
        bif.pat = ~pt;
      end
      if (poke && lat == 5) bif.start = 0;
      lat++;
    end
    e = sb.pop_front();
    chk("done_seen", bif.done, 1);
    chk("latency", lat, e.lat);
    chk("busy_at_done", bif.busy, 0);
    for (int p = 0; p < NUM_PAT; p++) begin
      chk($sformatf("cnt%0d", p), bif.cnt[p], e.cnt[p]);
      chk($sformatf("sat%0d", p), bif.sat[p], e.sat[p]);
    end
    bif.pat = pt;
    @(negedge clk);
    chk("done_one_cycle", bif.done, 0);
    chk("cnt_held", bif.cnt, e.cnt);
  endtask
  initial begin
    pat_t pt;
    bit dn;
    bif.start = 0;
    bif.pat = '0;
    load('{0});
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_cnt", bif.cnt, 0);
    chk("rst_sat", bif.sat, 0);
    chk("rst_addr", bif.rom_addr, 0);
    // basic counting, with duplicate pattern 2 counted independently
    load('{1, 2, 3, 4, 1, 2, 3, 15, 15});
    pt[0] = mk(1, 2, 3); pt[1] = mk(2, 3, 4); pt[2] = mk(1, 2, 3);
    pt[3] = mk(4, 1, 2); pt[4] = mk(3, 4, 2); pt[5] = mk(14, 14, 14);
    run(pt, 0);
    chk("t2_cnt0", bif.cnt[0], 2);
    chk("t2_cnt1", bif.cnt[1], 1);
    chk("t2_cnt2_dup", bif.cnt[2], 2);
    // start while busy is ignored; pattern changes mid-scan have no effect
    run(pt, 1);
    chk("t6_poke_cnt0", bif.cnt[0], 2);
    run(pt, 0);
    chk("t6_rerun_cnt1", bif.cnt[1], 1);
    // separator blocks matches across it
    load('{1, 1, 2, 15, 1, 2, 3, 15, 15});
    pt[0] = mk(1, 2, 3); pt[1] = mk(1, 1, 2); pt[2] = mk(1, 2, 1);
    pt[3] = mk(2, 1, 2); pt[4] = mk(2, 3, 1); pt[5] = mk(0, 0, 0);
    run(pt, 0);
    chk("t3_cnt0", bif.cnt[0], 1);
    chk("t3_cnt1", bif.cnt[1], 1);
    chk("t3_cnt3", bif.cnt[3], 0);
    // overlap behaviour
    load('{5, 5, 5, 5, 15, 15});
    pt = '0;
    pt[0] = mk(5, 5, 5);
    run(pt, 0);
`ifdef OVERLAP_EN
    chk("t4_cnt0", bif.cnt[0], 2);
`else
    chk("t4_cnt0", bif.cnt[0], 1);
`endif
    // mismatch restart: AAC inside AAAC
    load('{1, 1, 1, 2, 15, 15});
    pt[0] = mk(1, 1, 2);
    run(pt, 0);
    chk("restart_cnt0", bif.cnt[0], 1);
    // full ROM, no END, saturation
    load('{0});
    pt = '0;
    run(pt, 0);
    chk("t5_cnt0", bif.cnt[0], 15);
    chk("t5_sat0", bif.sat[0], 1);
    chk("t5_addr", bif.rom_addr, 255);
    // random streams over a small alphabet
    for (int r = 0; r < 4; r++) begin
      foreach (mem[a]) mem[a] = $urandom_range(0, 11) == 0 ? 4'hF : SYM_W'($urandom_range(0, 2));
      for (int p = 0; p < NUM_PAT; p++)
        pt[p] = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      run(pt, 0);
    end
    // reset mid-scan suppresses done and clears everything
    load('{1, 2, 3, 4, 1, 2, 3, 15, 15});
    pt[0] = mk(1, 2, 3);
    bif.pat = pt;
    @(posedge clk); #1 bif.start = 1;
    @(posedge clk); #1 bif.start = 0;
    repeat (4) @(posedge clk);
    dn = 0;
    #1 rst = 1;
    repeat (3) begin
      @(negedge clk);
      dn |= bif.done;
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t1_busy", bif.busy, 0);
    chk("t1_cnt", bif.cnt, 0);
    chk("t1_addr", bif.rom_addr, 0);
    repeat (15) begin
      @(negedge clk);
      dn |= bif.done;
    end
    chk("t1_no_done", dn, 0);
    chk("t1_idle_busy", bif.busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
